// File: rtl/hand_datapath.sv
// Card slots and hand scores for the baccarat table: a free-running rank counter
// supplies each dealt card, and a two-state FSM rescores the hands after every load.
module hand_datapath #(
    parameter int NUM_RANKS = 13,
    parameter int SCORE_MOD = 10
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       deal_valid,
    input  logic [2:0] deal_dest,
    output logic       deal_ready,
    input  logic       clear_hand,
    output logic [3:0] next_card,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic       score_valid,
    output logic       err,
    output logic       state_dbg
);

    typedef enum logic {IDLE = 1'b0, SCORE = 1'b1} state_t;

    state_t     state;
    logic [3:0] cards [6];
    logic       dest_ok;
    logic       slot_empty;

    // Handshake: a deal is taken on any edge where deal_valid && deal_ready are both
    // high. The requester holds deal_valid and deal_dest stable until that edge.
    // A clear_hand on the same edge wins, and the deal is not taken.
    assign deal_ready  = (state == IDLE);
    assign score_valid = (state == IDLE);
    assign state_dbg   = state;

    assign pcard1 = cards[0];
    assign pcard2 = cards[1];
    assign pcard3 = cards[2];
    assign dcard1 = cards[3];
    assign dcard2 = cards[4];
    assign dcard3 = cards[5];

    function automatic logic [4:0] card_value(input logic [3:0] c);
        return (c >= 4'd1 && c <= 4'd9) ? {1'b0, c} : 5'd0;
    endfunction

    function automatic logic [3:0] hand_score(input logic [3:0] a, input logic [3:0] b,
                                              input logic [3:0] c);
        logic [4:0] sum;
        sum = card_value(a) + card_value(b) + card_value(c);
        return 4'(sum % 5'(SCORE_MOD));
    endfunction

    always_comb begin
        dest_ok    = 1'b0;
        slot_empty = 1'b0;
        case (deal_dest)
            3'd0: begin dest_ok = 1'b1; slot_empty = (cards[0] == 4'd0); end
            3'd1: begin dest_ok = 1'b1; slot_empty = (cards[1] == 4'd0); end
            3'd2: begin dest_ok = 1'b1; slot_empty = (cards[2] == 4'd0); end
            3'd3: begin dest_ok = 1'b1; slot_empty = (cards[3] == 4'd0); end
            3'd4: begin dest_ok = 1'b1; slot_empty = (cards[4] == 4'd0); end
            3'd5: begin dest_ok = 1'b1; slot_empty = (cards[5] == 4'd0); end
            default: begin dest_ok = 1'b0; slot_empty = 1'b0; end
        endcase
    end

    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            state     <= IDLE;
            next_card <= 4'd1;
            pscore    <= 4'd0;
            dscore    <= 4'd0;
            err       <= 1'b0;
            for (int i = 0; i < 6; i++) cards[i] <= 4'd0;
        end else begin
            // The rank counter keeps running through SCORE and clear alike.
            next_card <= (next_card == 4'(NUM_RANKS)) ? 4'd1 : next_card + 4'd1;
            if (clear_hand) begin
                state  <= IDLE;
                pscore <= 4'd0;
                dscore <= 4'd0;
                err    <= 1'b0;
                for (int i = 0; i < 6; i++) cards[i] <= 4'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (deal_valid) begin
                            if (dest_ok && slot_empty) begin
                                cards[deal_dest] <= next_card;
                                state            <= SCORE;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    SCORE: begin
                        pscore <= hand_score(cards[0], cards[1], cards[2]);
                        dscore <= hand_score(cards[3], cards[4], cards[5]);
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hand_datapath.sv
// Directed bench for hand_datapath: a scoreboard queue holds the expected hand
// snapshot for each return to IDLE, and a monitor pops one entry per score_valid rise.
module tb_hand_datapath;

    logic       slow_clock;
    logic       resetb;
    logic       deal_valid;
    logic [2:0] deal_dest;
    logic       deal_ready;
    logic       clear_hand;
    logic [3:0] next_card;
    logic [3:0] pcard1, pcard2, pcard3;
    logic [3:0] dcard1, dcard2, dcard3;
    logic [3:0] pscore, dscore;
    logic       score_valid;
    logic       err;
    logic       state_dbg;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    hand_datapath dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .deal_valid (deal_valid),
        .deal_dest  (deal_dest),
        .deal_ready (deal_ready),
        .clear_hand (clear_hand),
        .next_card  (next_card),
        .pcard1     (pcard1),
        .pcard2     (pcard2),
        .pcard3     (pcard3),
        .dcard1     (dcard1),
        .dcard2     (dcard2),
        .dcard3     (dcard3),
        .pscore     (pscore),
        .dscore     (dscore),
        .score_valid(score_valid),
        .err        (err),
        .state_dbg  (state_dbg)
    );

    // Clock and safety limit
    initial begin
        slow_clock = 1'b0;
        forever #5 slow_clock = ~slow_clock;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "bench timeout");
    end

    function automatic logic [31:0] snap(input logic [3:0] p1, input logic [3:0] p2,
                                         input logic [3:0] p3, input logic [3:0] d1,
                                         input logic [3:0] d2, input logic [3:0] d3,
                                         input logic [3:0] ps, input logic [3:0] ds);
        return {p1, p2, p3, d1, d2, d3, ps, ds};
    endfunction

    function automatic logic [31:0] dut_snap();
        return {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: each return to IDLE presents a new scored hand
    initial begin
        logic prev_sv;
        prev_sv = 1'b1;
        forever begin
            @(negedge slow_clock);
            if (score_valid === 1'b1 && prev_sv !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_score_event", dut_snap(), 32'hxxxx_xxxx);
                end else begin
                    chk("score_snapshot", dut_snap(), exp_q.pop_front());
                end
            end
            prev_sv = score_valid;
        end
    end

    task automatic step();
        @(posedge slow_clock);
        #1;
    endtask

    // Driver: wait for the wanted rank with the block ready, then request one deal.
    // good=1 expects acceptance; finish=1 also steps through the SCORE cycle.
    task automatic deal(input logic [2:0] dest, input logic [3:0] rank,
                        input bit good, input bit finish);
        int n;
        n = 0;
        while (!(next_card == rank && deal_ready === 1'b1) && n < 40) begin
            step();
            n++;
        end
        chk("deal_wait_bound", 32'(n < 40), 32'd1);
        deal_valid = 1'b1;
        deal_dest  = dest;
        step();
        deal_valid = 1'b0;
        deal_dest  = 3'd0;
        if (good) chk("ready_low_in_score", 32'(deal_ready), 32'd0);
        else      chk("ready_high_after_bad", 32'(deal_ready), 32'd1);
        if (good && finish) begin
            step();
            chk("ready_back_after_score", 32'(deal_ready), 32'd1);
        end
    endtask

    task automatic do_clear();
        clear_hand = 1'b1;
        step();
        clear_hand = 1'b0;
        chk("clear_cards_scores", dut_snap(), 32'd0);
        chk("clear_err", 32'(err), 32'd0);
        chk("clear_idle", 32'(deal_ready), 32'd1);
    endtask

    initial begin
        resetb     = 1'b0;
        deal_valid = 1'b0;
        deal_dest  = 3'd0;
        clear_hand = 1'b0;

        // Reset for two edges
        step();
        step();
        chk("reset_snapshot", dut_snap(), 32'd0);
        chk("reset_next_card", 32'(next_card), 32'd1);
        chk("reset_ready", 32'(deal_ready), 32'd1);
        chk("reset_score_valid", 32'(score_valid), 32'd1);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_state", 32'(state_dbg), 32'd0);
        resetb = 1'b1;

        // Counter sequence 2..13,1,2
        for (int i = 0; i < 14; i++) begin
            step();
            chk("counter_seq", 32'(next_card), 32'((i + 1) % 13 + 1));
        end

        // Player 7 then 5 -> pscore 2
        exp_q.push_back(snap(7, 0, 0, 0, 0, 0, 7, 0));
        deal(3'd0, 4'd7, 1'b1, 1'b1);
        exp_q.push_back(snap(7, 5, 0, 0, 0, 0, 2, 0));
        deal(3'd1, 4'd5, 1'b1, 1'b1);
        do_clear();

        // Dealer K,10,9 -> 9; player 8,9,6 -> 3
        exp_q.push_back(snap(0, 0, 0, 13, 0, 0, 0, 0));
        deal(3'd3, 4'd13, 1'b1, 1'b1);
        exp_q.push_back(snap(0, 0, 0, 13, 10, 0, 0, 0));
        deal(3'd4, 4'd10, 1'b1, 1'b1);
        exp_q.push_back(snap(0, 0, 0, 13, 10, 9, 0, 9));
        deal(3'd5, 4'd9, 1'b1, 1'b1);
        exp_q.push_back(snap(8, 0, 0, 13, 10, 9, 8, 9));
        deal(3'd0, 4'd8, 1'b1, 1'b1);
        exp_q.push_back(snap(8, 9, 0, 13, 10, 9, 7, 9));
        deal(3'd1, 4'd9, 1'b1, 1'b1);
        exp_q.push_back(snap(8, 9, 6, 13, 10, 9, 3, 9));
        deal(3'd2, 4'd6, 1'b1, 1'b1);

        // Bad destination, then occupied slot: err sticky, cards unchanged
        deal(3'd6, 4'd2, 1'b0, 1'b0);
        chk("err_bad_dest", 32'(err), 32'd1);
        chk("cards_after_bad_dest", dut_snap(), snap(8, 9, 6, 13, 10, 9, 3, 9));
        deal(3'd0, 4'd4, 1'b0, 1'b0);
        chk("err_sticky", 32'(err), 32'd1);
        chk("cards_after_occupied", dut_snap(), snap(8, 9, 6, 13, 10, 9, 3, 9));
        step();
        chk("err_still_set", 32'(err), 32'd1);
        do_clear();

        // clear_hand beats a simultaneous deal
        deal_valid = 1'b1;
        deal_dest  = 3'd0;
        clear_hand = 1'b1;
        step();
        deal_valid = 1'b0;
        clear_hand = 1'b0;
        chk("clear_beats_deal", dut_snap(), 32'd0);
        chk("clear_beats_deal_idle", 32'(deal_ready), 32'd1);

        // Clear during SCORE discards the pending update
        exp_q.push_back(snap(4, 0, 0, 0, 0, 0, 4, 0));
        deal(3'd0, 4'd4, 1'b1, 1'b1);
        exp_q.push_back(32'd0);
        deal(3'd1, 4'd3, 1'b1, 1'b0);
        chk("loaded_before_clear", dut_snap(), snap(4, 3, 0, 0, 0, 0, 4, 0));
        do_clear();

        // Reset during SCORE
        exp_q.push_back(snap(0, 0, 0, 6, 0, 0, 0, 6));
        deal(3'd3, 4'd6, 1'b1, 1'b1);
        exp_q.push_back(32'd0);
        deal(3'd4, 4'd2, 1'b1, 1'b0);
        resetb = 1'b0;
        step();
        resetb = 1'b1;
        chk("midscore_reset_snapshot", dut_snap(), 32'd0);
        chk("midscore_reset_next_card", 32'(next_card), 32'd1);
        chk("midscore_reset_ready", 32'(deal_ready), 32'd1);
        chk("midscore_reset_err", 32'(err), 32'd0);

        step();
        step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
